interlayer_addcp: RTL and testbench

Tx-side cyclic-prefix insertion between the IFFT output and the DAC/interpolation chain. Accepts complex symbols of `fftsize` samples, buffers them in a ping-pong RAM, and emits each symbol as `cpsize` prefix samples (the last `cpsize` samples of the symbol) followed by all `fftsize` samples. The output is a continuous stream of `fftsize+cpsize` samples per symbol. Backpressure to the IFFT side is through `iready`, since output rate exceeds input rate.

---
 rtl/interlayer_addcp_pkg.sv | 12 +
 rtl/addcp_dpram.sv | 25 ++
 rtl/interlayer_addcp.sv | 186 ++++++++++++++++++
 tb/tb_interlayer_addcp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/interlayer_addcp_pkg.sv
// rtl/interlayer_addcp_pkg.sv - shared types and helpers for the cyclic-prefix inserter
package interlayer_addcp_pkg;

  typedef enum logic [1:0] {IDLE, CP, BODY} addcp_state_t;

  localparam int N_SYMB = 50;

  function automatic int cnt_width(input int fftsize, input int cpsize);
    return $clog2(fftsize + cpsize);
  endfunction

endpackage

// File: rtl/addcp_dpram.sv
// rtl/addcp_dpram.sv - simple dual-port RAM, one write port, one registered read port
module addcp_dpram #(
  parameter int WIDTH = 24,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/interlayer_addcp.sv
// rtl/interlayer_addcp.sv - ping-pong buffered cyclic-prefix inserter
// Define INTERLAYER_ADDCP_SYMCNT_EN to build the count_frame symbol counter.
module interlayer_addcp
  import interlayer_addcp_pkg::*;
#(
  parameter int fft_depth = 12,
  parameter int fftsize   = 1024,
  parameter int cpsize    = 32,
  parameter int n_symb    = N_SYMB
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 isop,
  input  logic                 ival,
  input  logic [fft_depth-1:0] in_real_data,
  input  logic [fft_depth-1:0] in_imag_data,
  output logic                 iready,
  output logic                 osop,
  output logic                 oeop,
  output logic                 oval,
  output logic [fft_depth-1:0] out_real_data,
  output logic [fft_depth-1:0] out_imag_data,
  output logic [6:0]           count_frame,
  output logic                 err
);

  localparam int AW = $clog2(fftsize);
  localparam int CW = cnt_width(fftsize, cpsize);
  localparam int DW = 2 * fft_depth;
  localparam logic [AW-1:0] LAST_IDX   = AW'(fftsize - 1);
  localparam logic [CW-1:0] POS_CP_END = CW'(cpsize - 1);
  localparam logic [CW-1:0] POS_LAST   = CW'(fftsize + cpsize - 1);
  localparam logic [CW-1:0] POS_OFF    = CW'(fftsize - cpsize);

  logic [AW-1:0] r_wr_cnt;
  logic          r_wr_bank;
  logic          r_synced;
  logic          r_err;
  logic [1:0]    r_bank_full;

  addcp_state_t  r_state;
  logic [CW-1:0] r_rd_pos;
  logic          r_rd_bank;
  logic          r_v1, r_sop1, r_eop1;

  logic                 r_oval, r_osop, r_oeop;
  logic [fft_depth-1:0] r_out_re, r_out_im;

  logic          w_acc, w_we, w_wr_last, w_rd_last, w_re, w_sop;
  logic [AW-1:0] w_widx;
  logic [AW:0]   w_waddr, w_raddr;
  logic [DW-1:0] w_q;
  logic [1:0]    w_set, w_clr;

  // Write side: symbols land in r_wr_bank, indexed by r_wr_cnt
  assign iready    = ~r_bank_full[r_wr_bank];
  assign w_acc     = ival & iready;
  assign w_we      = w_acc & (isop | (r_synced & (r_wr_cnt != '0)));
  assign w_widx    = isop ? '0 : r_wr_cnt;
  assign w_waddr   = {r_wr_bank, w_widx};
  assign w_wr_last = w_we & ~isop & (r_wr_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_synced  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if ((ival & ~iready) |
          (w_acc & isop & (r_wr_cnt != '0)) |
          (w_acc & ~isop & r_synced & (r_wr_cnt == '0)))
        r_err <= 1'b1;
      if (w_acc & isop) begin
        r_synced <= 1'b1;
        r_wr_cnt <= AW'(1);
      end else if (w_wr_last) begin
        r_wr_cnt  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else if (w_we) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  // Set and clear always hit different banks, so both apply
  assign w_set = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_clr = w_rd_last ? (2'b01 << r_rd_bank) : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_bank_full <= 2'b00;
    else      r_bank_full <= (r_bank_full & ~w_clr) | w_set;
  end

  // r_rd_pos walks 0..fftsize+cpsize-1; adding fftsize-cpsize mod fftsize yields the prefix-then-body address
  assign w_re      = (r_state != IDLE);
  assign w_sop     = (r_state == CP) & (r_rd_pos == '0);
  assign w_rd_last = (r_state == BODY) & (r_rd_pos == POS_LAST);
  assign w_raddr   = {r_rd_bank, AW'(r_rd_pos + POS_OFF)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rd_pos  <= '0;
      r_rd_bank <= 1'b0;
      r_v1      <= 1'b0;
      r_sop1    <= 1'b0;
      r_eop1    <= 1'b0;
    end else begin
      r_v1   <= w_re;
      r_sop1 <= w_sop;
      r_eop1 <= w_rd_last;
      case (r_state)
        IDLE: begin
          if (r_bank_full[r_rd_bank]) begin
            r_state  <= CP;
            r_rd_pos <= '0;
          end
        end
        CP: begin
          r_rd_pos <= r_rd_pos + 1'b1;
          if (r_rd_pos == POS_CP_END) r_state <= BODY;
        end
        BODY: begin
          if (w_rd_last) begin
            r_rd_bank <= ~r_rd_bank;
            r_rd_pos  <= '0;
            r_state   <= r_bank_full[~r_rd_bank] ? CP : IDLE;
          end else begin
            r_rd_pos <= r_rd_pos + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  addcp_dpram #(.WIDTH(DW), .AW(AW + 1)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata ({in_real_data, in_imag_data}),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oval   <= 1'b0;
      r_osop   <= 1'b0;
      r_oeop   <= 1'b0;
      r_out_re <= '0;
      r_out_im <= '0;
    end else begin
      r_oval   <= r_v1;
      r_osop   <= r_sop1;
      r_oeop   <= r_eop1;
      r_out_re <= r_v1 ? w_q[DW-1:fft_depth] : '0;
      r_out_im <= r_v1 ? w_q[fft_depth-1:0]  : '0;
    end
  end

`ifdef INTERLAYER_ADDCP_SYMCNT_EN
  logic [6:0] r_count_frame;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_count_frame <= '0;
    else if (r_oeop)
      r_count_frame <= (r_count_frame == 7'(n_symb - 1)) ? '0 : r_count_frame + 1'b1;
  end

  assign count_frame = r_count_frame;
`else
  assign count_frame = '0;
`endif

  assign osop          = r_osop;
  assign oeop          = r_oeop;
  assign oval          = r_oval;
  assign out_real_data = r_out_re;
  assign out_imag_data = r_out_im;
  assign err           = r_err;

endmodule

// File: tb/tb_interlayer_addcp.sv
// tb/tb_interlayer_addcp.sv - self-checking bench for interlayer_addcp
module tb_interlayer_addcp;

  localparam int FD  = 12;
  localparam int FS  = 1024;
  localparam int CPS = 32;
  localparam int NS  = 50;
  localparam int SL  = FS + CPS;

`ifdef INTERLAYER_ADDCP_SYMCNT_EN
  localparam logic [6:0] CF_MASK = 7'h7f;
`else
  localparam logic [6:0] CF_MASK = 7'h00;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          isop = 1'b0, ival = 1'b0;
  logic [FD-1:0] in_re = '0, in_im = '0;
  logic          iready, osop, oeop, oval, err;
  logic [FD-1:0] out_re, out_im;
  logic [6:0]    count_frame;

  always #5 clk = ~clk;

  interlayer_addcp #(.fft_depth(FD), .fftsize(FS), .cpsize(CPS), .n_symb(NS)) dut (
    .clk           (clk),
    .rst           (rst),
    .isop          (isop),
    .ival          (ival),
    .in_real_data  (in_re),
    .in_imag_data  (in_im),
    .iready        (iready),
    .osop          (osop),
    .oeop          (oeop),
    .oval          (oval),
    .out_real_data (out_re),
    .out_imag_data (out_im),
    .count_frame   (count_frame),
    .err           (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_cf(input int syms);
    return 7'(syms % NS) & CF_MASK;
  endfunction

  // Reference model: assemble accepted symbols, queue their prefixed form, compare output order
  logic [2*FD-1:0] cur[$];
  logic [2*FD-1:0] expq[$];
  logic [2*FD-1:0] smp;
  bit synced, exp_err, saw_stall;
  int out_idx, out_syms, run, max_run, cf_eop50;

  always @(negedge clk) begin
    if (!rst) begin
      check("reset_outputs", {osop, oeop, oval, out_re, out_im, count_frame, err}, 0);
      check("reset_iready", iready, 1);
      cur.delete();
      expq.delete();
      synced = 0; exp_err = 0; out_idx = 0; out_syms = 0; run = 0;
    end else begin
      check("err", err, exp_err);
      if (oval) begin
        run++;
        if (run > max_run) max_run = run;
        if (expq.size() == 0) begin
          check("spurious_oval", oval, 0);
        end else begin
          smp = expq.pop_front();
          check("out_sample", {osop, oeop, out_re, out_im, count_frame},
                {out_idx == 0, out_idx == SL-1, smp, exp_cf(out_syms)});
          if (out_idx == SL-1 && out_syms == NS-1) cf_eop50 = count_frame;
          out_idx++;
          if (out_idx == SL) begin
            out_idx = 0;
            out_syms++;
          end
        end
      end else begin
        run = 0;
        check("idle_outputs", {osop, oeop, out_re, out_im}, 0);
      end
      if (!iready) saw_stall = 1;
      if (ival && !iready) exp_err = 1;
      if (ival && iready) begin
        if (isop) begin
          if (cur.size() != 0) exp_err = 1;
          cur.delete();
          cur.push_back({in_re, in_im});
          synced = 1;
        end else if (synced) begin
          if (cur.size() == 0) begin
            exp_err = 1;
          end else begin
            cur.push_back({in_re, in_im});
            if (cur.size() == FS) begin
              for (int k = FS-CPS; k < FS; k++) expq.push_back(cur[k]);
              for (int k = 0; k < FS; k++) expq.push_back(cur[k]);
              cur.delete();
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 0; ival = 0; isop = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    max_run = 0; saw_stall = 0; cf_eop50 = 999;
  endtask

  // polite: withhold ival while iready is low; rnd: random data and random idle gaps
  task automatic send_sym(input int n, input int base, input bit sop, input bit polite, input bit rnd);
    int i = 0;
    while (i < n) begin
      @(posedge clk); #1;
      if (polite && (!iready || (rnd && $urandom_range(0, 7) == 0))) begin
        ival = 0; isop = 0;
      end else begin
        ival  = 1;
        isop  = sop && (i == 0);
        in_re = rnd ? FD'($urandom) : FD'(base + i);
        in_im = ~in_re;
        if (iready) i++;
      end
    end
  endtask

  task automatic stop_in();
    @(posedge clk); #1;
    ival = 0; isop = 0;
  endtask

  task automatic osop_latency();
    logic [3:0] pat;
    @(posedge clk); #1;
    ival = 0; isop = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat[k] = osop;
    end
    check("osop_latency", pat, 4'b1000);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((expq.size() != 0 || out_idx != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_time", expq.size(), 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int junk;
    int restart;
    int nsym;
    bit polite;
    bit rnd;
    bit stray;
    bit exp_err;
    int exp_run;
    bit exp_stall;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0,  -1, 1, 1, 0, 0, 0, SL,   0};
    vecs[1] = '{5,  -1, 1, 1, 1, 0, 0, SL,   0};
    vecs[2] = '{0, 500, 1, 1, 0, 0, 1, SL,   0};
    vecs[3] = '{0,  -1, 3, 1, 0, 0, 0, 3*SL, 1};
    vecs[4] = '{0,  -1, 3, 0, 1, 0, 1, 3*SL, 1};
    vecs[5] = '{0,  -1, 1, 1, 1, 1, 1, SL,   0};

    for (int r = 0; r < 6; r++) begin
      do_reset();
      if (vecs[r].junk > 0) send_sym(vecs[r].junk, 3000, 0, 1, 0);
      if (vecs[r].restart > 0) send_sym(vecs[r].restart, 2048, 1, 1, 0);
      for (int s = 0; s < vecs[r].nsym; s++) send_sym(FS, s*FS, 1, vecs[r].polite, vecs[r].rnd);
      if (vecs[r].nsym == 1) osop_latency();
      else stop_in();
      if (vecs[r].stray) begin
        send_sym(1, 7, 0, 1, 0);
        stop_in();
      end
      wait_drain(8*SL);
      check("row_err", err, vecs[r].exp_err);
      check("row_symbols", out_syms, vecs[r].nsym);
      check("row_oval_run", max_run, vecs[r].exp_run);
      check("row_stall", saw_stall, vecs[r].exp_stall);
    end

    // Reset while the body of a symbol is being output
    begin
      int n = 0;
      do_reset();
      send_sym(FS, 0, 1, 1, 0);
      stop_in();
      while (out_idx != CPS + 300 && n < 4*SL) begin
        @(posedge clk);
        n++;
      end
      check("reach_body_300", out_idx, CPS + 300);
      #1 rst = 0;
      #1;
      check("rst_async_outputs", {osop, oeop, oval, out_re, out_im, count_frame, err}, 0);
      check("rst_async_iready", iready, 1);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      send_sym(FS, 500, 1, 1, 1);
      osop_latency();
      wait_drain(4*SL);
      check("post_reset_symbols", out_syms, 1);
      check("post_reset_err", err, 0);
    end

    // Symbol-count wrap over 51 back-to-back symbols
    do_reset();
    for (int s = 0; s < 51; s++) send_sym(FS, s*37, 1, 1, 0);
    stop_in();
    wait_drain(4*SL);
    check("wrap_symbols", out_syms, 51);
    check("cf_at_50th_eop", cf_eop50, exp_cf(49));
    check("cf_after_wrap", count_frame, exp_cf(51));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
